// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcodes, field
// positions, the fetch state encoding and the halt marker word.
package fetch_pkg;

  localparam logic [5:0] OP_ADDU  = 6'd1;
  localparam logic [5:0] OP_BEQ   = 6'd2;
  localparam logic [5:0] OP_LW    = 6'd3;
  localparam logic [5:0] OP_MUL   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd5;
  localparam logic [5:0] OP_J     = 6'd7;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch queue with wrap-around pointers and an occupancy
// count; flush empties it in one cycle, push+pop on a full queue is legal.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, loadable imem, 2-entry prefetch queue and
// redirect handling. Optional jump predecode under FETCH_JUMP_PREDECODE_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic              halted
);

  localparam int ENTRY_W = DATA_W + PC_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

  state_t              state;
  state_t              state_next;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_next;
  logic [DATA_W-1:0]   imem [IMEM_DEPTH];
  logic [PC_W-1:0]     fetch_addr;
  logic [DATA_W-1:0]   fetch_word;
  logic                fetch_en;
  logic                push;
  logic                pop;
  logic                flush;
  logic                slot_free;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;

  // A start pulse fetches address 0 in the same cycle so the first
  // instruction is visible to decode one cycle later.
  assign fetch_addr = (state == RUN) ? pc : '0;
  assign fetch_word = imem[fetch_addr];
  assign pop        = inst_valid && inst_ready;
  assign slot_free  = !full || pop;

  always_ff @(posedge clock) begin
    if (state == IDLE && load_en) imem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
          fetch_en   = 1'b1;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end else begin
          fetch_en = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_next = RUN;
          flush      = 1'b1;
          pc_next    = redirect_pc;
        end else if (start) begin
          state_next = RUN;
          pc_next    = '0;
          fetch_en   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (fetch_en && slot_free) begin
      if (fetch_word == HALT_WORD) begin
        state_next = HALT;
        pc_next    = fetch_addr;
`ifdef FETCH_JUMP_PREDECODE_EN
      end else if (opcode(fetch_word) == OP_J) begin
        pc_next = fetch_word[PC_W-1:0];
`endif
      end else begin
        push    = 1'b1;
        pc_next = fetch_addr + 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({fetch_word, fetch_addr}),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_data  = empty ? '0 : head[ENTRY_W-1:PC_W];
  assign inst_pc    = empty ? '0 : head[PC_W-1:0];
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven cycle vectors plus hand-written
// sequences for reset, wrap-around and jump handling.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W   = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic              clock          = 1'b0;
  logic              reset_n        = 1'b0;
  logic              start          = 1'b0;
  logic              load_en        = 1'b0;
  logic [PC_W-1:0]   load_addr      = '0;
  logic [DATA_W-1:0] load_data      = '0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc    = '0;
  logic              inst_ready     = 1'b0;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;
  logic              halted;

  int tests    = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic       st;
    logic       rdy;
    logic       rv;
    logic [4:0] rpc;
    logic       ld;
    logic       exp_valid;
    logic [4:0] exp_pc;
    logic       exp_halted;
  } vec_t;

  vec_t vecs[$];
  int   got[$];
  int   exp_seq[11];

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input int i);
    return {OP_ADDIU, 5'd0, 5'd1, 16'(i + 1)};
  endfunction

  function automatic vec_t mk(input logic st, input logic rdy, input logic rv,
                              input logic [4:0] rpc, input logic ld,
                              input logic ev, input logic [4:0] epc, input logic eh);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ld = ld;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_halted = eh;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = PC_W'(addr);
    load_data = data;
    model_mem[addr] = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    start          = v.st;
    inst_ready     = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    load_en        = v.ld;
    load_addr      = 5'd6;
    load_data      = 32'h0;
  endtask

  task automatic check_output(input string tag, input int idx, input vec_t v);
    check($sformatf("%s[%0d] valid", tag, idx), {31'b0, inst_valid}, {31'b0, v.exp_valid});
    check($sformatf("%s[%0d] halted", tag, idx), {31'b0, halted}, {31'b0, v.exp_halted});
    if (v.exp_valid) begin
      check($sformatf("%s[%0d] pc", tag, idx), {27'b0, inst_pc}, {27'b0, v.exp_pc});
      check($sformatf("%s[%0d] data", tag, idx), inst_data, model_mem[v.exp_pc]);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(tag, i, vecs[i]);
      step();
    end
    start = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; load_en = 1'b0;
    vecs.delete();
  endtask

  initial begin
    // Reset held across clock edges
    step();
    step();
    check("reset valid", {31'b0, inst_valid}, 32'd0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset pc", {27'b0, inst_pc}, 32'd0);
    check("reset data", inst_data, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) load_word(i, (i == 3) ? 32'h0 : word_at(i));

    // Straight-line run into the halt word at address 3
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    run_table("halt");

    // Restart from HALT with backpressure, then drain while halting again
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    run_table("bp");

    // Fill the queue, then reset mid-cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    run_table("fill");
    #2 reset_n = 1'b0;
    #1;
    check("midreset valid", {31'b0, inst_valid}, 32'd0);
    check("midreset halted", {31'b0, halted}, 32'd0);
    check("midreset data", inst_data, 32'd0);
    step();
    reset_n = 1'b1;
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    run_table("idle");

    load_word(3, word_at(3));

    // Redirect with a full queue, ignored load/start in RUN, redirect+dequeue
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 1, 9, 0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 9, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 10, 0));
    // Keep streaming through the top of memory and around to 0
    for (int k = 11; k < 34; k++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5'(k % 32), 0));
    run_table("redir");

    // Jump word at address 9
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    load_word(9, {OP_J, 26'd1});
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 1, 2};
`else
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
`endif
    start      = 1'b1;
    inst_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (inst_valid && inst_ready) begin
        got.push_back(int'(inst_pc));
        check($sformatf("jump data pc%0d", inst_pc), inst_data, model_mem[inst_pc]);
      end
      step();
      start = 1'b0;
    end
    inst_ready = 1'b0;
    check("jump count>=11", {31'b0, got.size() >= 11}, 32'd1);
    for (int i = 0; i < 11; i++)
      check($sformatf("jump seq[%0d]", i), (i < got.size()) ? got[i] : -1, exp_seq[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end feeding the multi-cycle MIPS-style datapath's decode stage.
- Owns the PC and a loadable instruction memory; prefetches into a 2-entry queue.
- Hands instructions to decode over a valid/ready handshake.
- Accepts redirects (taken beq, j, jr) from execute, which flush the queue.

Parameters:
- IMEM_DEPTH, 32, instruction words in memory.
- PC_W, 5, PC width in word units (clog2 of IMEM_DEPTH).
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, prefetch queue entries.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; IDLE->RUN with PC=0.
- load_en  in  1  imem write strobe; honoured only in IDLE.
- load_addr  in  PC_W  imem write address.
- load_data  in  DATA_W  imem write data.
- redirect_valid  in  1  execute requests a new PC.
- redirect_pc  in  PC_W  redirect target (word index).
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  PC_W  PC of head instruction.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=0, queue empty, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
  - imem contents are not cleared.
  - Reset mid-operation aborts everything immediately.
- States:
  - IDLE: load_en writes imem[load_addr]. start -> RUN, pc=0.
  - RUN: see "RUN fetch" below.
  - HALT: halted=1. No fetch. Queue still drains to decode. redirect_valid -> RUN at redirect_pc, queue flushed. start -> RUN, pc=0.
- RUN fetch:
  - Each cycle where the queue has a free slot after this cycle's dequeue, read imem[pc] combinationally, enqueue {imem[pc], pc}, then pc <= pc+1.
  - Latency: start in cycle N -> inst_valid=1 with inst_pc=0 in cycle N+1.
  - Sustained throughput is 1 instruction per cycle while inst_ready=1.
- Halt word: a fetched word equal to all-zeros is not enqueued; state -> HALT and pc holds that address.
- PC wrap: pc = IMEM_DEPTH-1 increments to 0 (modular, PC_W bits).
- Handshake:
  - Transfer when inst_valid && inst_ready.
  - inst_data and inst_pc stay stable while inst_valid=1 and inst_ready=0.
  - Full queue: fetch stalls and pc holds.
- Redirect, in RUN or HALT:
  - Flushes all queue entries and suppresses this cycle's fetch.
  - pc <= redirect_pc; inst_valid=0 the next cycle.
  - First instruction from the target appears 2 cycles after the redirect cycle.
- Simultaneous events:
  - Redirect beats dequeue: a handshake in the redirect cycle still counts as accepted by decode.
  - Redirect beats halt-word detection.
  - start while in RUN is ignored.
  - load_en outside IDLE is ignored.
- Queue: circular buffer with wrap-around read/write pointers and an occupancy count of 0..FIFO_DEPTH. Simultaneous enqueue+dequeue on a full queue is allowed.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- Defined:
  - A fetched word with op[31:26]=6'b000111 (j) is not enqueued.
  - pc <= word[PC_W-1:0] next cycle; no bubble beyond that cycle.
  - Decode never sees j.
- Undefined: j passes through like any instruction, and execute must redirect.

Decomposition:
- Package fetch_pkg:
  - Opcode constants: OP_ADDU=1, OP_BEQ=2, OP_LW=3, OP_MUL=4, OP_ADDIU=5, OP_J=7.
  - Field positions: op 31:26, rs 25:21, rt 20:16, rd 15:11, imm 15:0.
  - State enum IDLE/RUN/HALT.
  - HALT_WORD constant.
- Sub-module fetch_fifo: parameterised queue with push/pop/flush, full/empty/count.

Test Plan:
- Reset/idle: hold reset_n=0, then release -> inst_valid=0, halted=0, pc=0. load 3 words at addresses 0..2 plus zero at 3, pulse start -> inst_pc 0,1,2 on consecutive cycles with inst_ready=1, then halted=1 and no 4th valid.
- Backpressure: inst_ready=0 for 5 cycles after start -> inst_valid=1, inst_pc=0 held stable, queue count=2, pc=2. Raise inst_ready -> pcs 0,1,2 in order, no loss or duplicate.
- Redirect: while at pc=5 with 2 queued, redirect_valid with redirect_pc=1 -> next cycle inst_valid=0; the cycle after, inst_pc=1; entries for pcs 3,4 never delivered.
- Simultaneous: redirect with inst_ready=1 and valid head pc=3 -> pc 3 counted transferred, queue empty next cycle, then pc 9 (the target).
- Wrap: program with no zero word, run to pc=31 -> next inst_pc=0.
- Reset mid-run: reset_n=0 while queue full -> immediately inst_valid=0, state IDLE; imem contents preserved on restart.
- With FETCH_JUMP_PREDECODE_EN: word at address 9 = j to 1 -> decode sees pcs 8 then 1, never 9.
